// File: rtl/tcp_checksum_insert_pkg.sv
// Shared widths and FSM encoding for the TX checksum insertion path.
package tcp_checksum_insert_pkg;
    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_KEEP_W = 64;
    localparam int CKSUM_W     = 16;

    typedef enum logic [0:0] {
        WAIT_CKS = 1'b0,
        BODY     = 1'b1
    } ins_state_e;
endpackage

// File: rtl/tcp_cks_sync_fifo.sv
// First-word-fall-through synchronous FIFO; ready/full derived from occupancy only.
module tcp_cks_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_ok, rd_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok)      cnt_d = cnt_q + 1'b1;
        else if (rd_ok && !wr_ok) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/tcp_checksum_insert.sv
// Holds each TX packet until its checksum arrives, then replays it with the
// checksum patched into beat 0.
module tcp_checksum_insert
    import tcp_checksum_insert_pkg::*;
#(
    parameter int CKSUM_BYTE_OFFSET = 36,
    parameter int PKT_FIFO_DEPTH    = 32,
    parameter int CKS_FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXIS_DATA_W-1:0] S_AXIS_TDATA,
    input  logic [AXIS_KEEP_W-1:0] S_AXIS_TKEEP,
    input  logic                   S_AXIS_TVALID,
    input  logic                   S_AXIS_TLAST,
    output logic                   S_AXIS_TREADY,
    input  logic [CKSUM_W-1:0]     S_CKS_TDATA,
    input  logic                   S_CKS_TVALID,
    output logic                   S_CKS_TREADY,
    output logic [AXIS_DATA_W-1:0] M_AXIS_TDATA,
    output logic [AXIS_KEEP_W-1:0] M_AXIS_TKEEP,
    output logic                   M_AXIS_TVALID,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY,
    output logic                   err_oversize
);
    localparam int PW = AXIS_DATA_W + AXIS_KEEP_W + 1;

    logic                   pkt_full, pkt_empty, pkt_rd;
    logic                   cks_full, cks_empty, cks_rd;
    logic [PW-1:0]          pkt_head;
    logic [CKSUM_W-1:0]     cks_head;
    logic [AXIS_DATA_W-1:0] head_data, patched;
    logic [AXIS_KEEP_W-1:0] head_keep;
    logic                   head_last, adv;

    ins_state_e             state_q, state_d;
    logic [AXIS_DATA_W-1:0] m_data_q, m_data_d;
    logic [AXIS_KEEP_W-1:0] m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;
    logic                   m_valid_q, m_valid_d;
    logic                   err_q, err_d;

    assign S_AXIS_TREADY = ~pkt_full;
    assign S_CKS_TREADY  = ~cks_full;

    tcp_cks_sync_fifo #(.W(PW), .DEPTH(PKT_FIFO_DEPTH)) u_pkt_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (S_AXIS_TVALID),
        .wr_data ({S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA}),
        .rd_en   (pkt_rd),
        .rd_data (pkt_head),
        .full    (pkt_full),
        .empty   (pkt_empty)
    );

    tcp_cks_sync_fifo #(.W(CKSUM_W), .DEPTH(CKS_FIFO_DEPTH)) u_cks_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (S_CKS_TVALID),
        .wr_data (S_CKS_TDATA),
        .rd_en   (cks_rd),
        .rd_data (cks_head),
        .full    (cks_full),
        .empty   (cks_empty)
    );

    assign {head_last, head_keep, head_data} = pkt_head;

    // Checksum lanes are overwritten even if TKEEP masks them.
    always_comb begin
        patched = head_data;
        patched[CKSUM_BYTE_OFFSET*8 +: CKSUM_W] = cks_head;
    end

    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        pkt_rd    = 1'b0;
        cks_rd    = 1'b0;
        err_d     = err_q | (pkt_full & cks_empty);
        adv       = ~m_valid_q | M_AXIS_TREADY;

        if (adv) m_valid_d = 1'b0;

        case (state_q)
            WAIT_CKS: begin
                if (adv && !pkt_empty && !cks_empty) begin
                    m_data_d  = patched;
                    m_keep_d  = head_keep;
                    m_last_d  = head_last;
                    m_valid_d = 1'b1;
                    pkt_rd    = 1'b1;
                    cks_rd    = 1'b1;
                    state_d   = head_last ? WAIT_CKS : BODY;
                end
            end
            BODY: begin
                if (adv && !pkt_empty) begin
                    m_data_d  = head_data;
                    m_keep_d  = head_keep;
                    m_last_d  = head_last;
                    m_valid_d = 1'b1;
                    pkt_rd    = 1'b1;
                    if (head_last) state_d = WAIT_CKS;
                end
            end
            default: state_d = WAIT_CKS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_CKS;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TKEEP  = m_keep_q;
    assign M_AXIS_TLAST  = m_last_q;
    assign M_AXIS_TVALID = m_valid_q;
    assign err_oversize  = err_q;
endmodule

// File: tb/tb_tcp_checksum_insert.sv
// Directed + randomized bench for tcp_checksum_insert against a packet-level model.
module tb_tcp_checksum_insert;
    localparam int OFF = 36;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] S_AXIS_TDATA = '0;
    logic [63:0]  S_AXIS_TKEEP = '0;
    logic         S_AXIS_TVALID = 1'b0;
    logic         S_AXIS_TLAST = 1'b0;
    logic         S_AXIS_TREADY;
    logic [15:0]  S_CKS_TDATA = '0;
    logic         S_CKS_TVALID = 1'b0;
    logic         S_CKS_TREADY;
    logic [511:0] M_AXIS_TDATA;
    logic [63:0]  M_AXIS_TKEEP;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY = 1'b1;
    logic         err_oversize;

    always #5 clk = ~clk;

    tcp_checksum_insert dut (
        .clk(clk), .rst(rst),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_CKS_TDATA(S_CKS_TDATA), .S_CKS_TVALID(S_CKS_TVALID), .S_CKS_TREADY(S_CKS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .err_oversize(err_oversize)
    );

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        bit           f;
    } beat_t;

    beat_t        tx_q[$];
    beat_t        mdl_q[$];
    logic [15:0]  cks_tx_q[$];
    logic [15:0]  cks_mdl[$];
    int           n_vec = 0, n_err = 0, cyc = 0;
    int           out_cnt = 0, first_cyc = 0, last_cyc = 0;
    bit           en_rand = 0, bp = 0, hold_lo = 0, exp_first = 1, stall_prev = 0;
    logic [511:0] prev_d = '0, first_out = '0, tmp;
    logic         prev_l = 1'b0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        beat_t        b, e;
        logic [511:0] x;
        S_AXIS_TVALID = (tx_q.size() > 0) && (!en_rand || $urandom_range(0, 1) == 1);
        if (tx_q.size() > 0) begin
            S_AXIS_TDATA = tx_q[0].d;
            S_AXIS_TKEEP = tx_q[0].k;
            S_AXIS_TLAST = tx_q[0].l;
        end
        S_CKS_TVALID = (cks_tx_q.size() > 0) && (!en_rand || $urandom_range(0, 1) == 1);
        if (cks_tx_q.size() > 0) S_CKS_TDATA = cks_tx_q[0];
        M_AXIS_TREADY = hold_lo ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
        @(negedge clk);
        if (!rst) begin
            if (stall_prev) begin
                chk("stall_valid", 512'(M_AXIS_TVALID), 512'd1);
                chk("stall_data", M_AXIS_TDATA, prev_d);
                chk("stall_last", 512'(M_AXIS_TLAST), 512'(prev_l));
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                out_cnt++;
                if (out_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
                n_vec++;
                assert (mdl_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_beat: got an output beat, want none");
                end
                if (mdl_q.size() > 0) begin
                    e = mdl_q.pop_front();
                    x = e.d;
                    if (e.f) begin
                        n_vec++;
                        assert (cks_mdl.size() > 0) else begin
                            n_err++;
                            $error("FAIL early_emit: got beat 0, want wait for checksum");
                        end
                        if (cks_mdl.size() > 0) x[OFF*8 +: 16] = cks_mdl.pop_front();
                        first_out = M_AXIS_TDATA;
                    end
                    chk("out_data", M_AXIS_TDATA, x);
                    chk("out_keep", 512'(M_AXIS_TKEEP), 512'(e.k));
                    chk("out_last", 512'(M_AXIS_TLAST), 512'(e.l));
                end
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                b = tx_q.pop_front();
                b.f = exp_first;
                exp_first = b.l;
                mdl_q.push_back(b);
            end
            if (S_CKS_TVALID && S_CKS_TREADY) cks_mdl.push_back(cks_tx_q.pop_front());
            stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_d = M_AXIS_TDATA;
            prev_l = M_AXIS_TLAST;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_pkt(input int n, input bit zero, input logic [63:0] keep, input bit has_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = '0;
            if (!zero) for (int j = 0; j < 16; j++) b.d[j*32 +: 32] = $urandom;
            b.k = keep;
            b.l = has_last && (i == n - 1);
            b.f = 0;
            tx_q.push_back(b);
        end
    endtask

    task automatic send_all();
        int k = 0;
        while ((tx_q.size() > 0 || cks_tx_q.size() > 0) && k < 500) begin tick(); k++; end
        chk("send_timeout", 512'(tx_q.size() + cks_tx_q.size()), 512'd0);
    endtask

    task automatic drain();
        int k = 0;
        while ((tx_q.size() > 0 || cks_tx_q.size() > 0 || mdl_q.size() > 0) && k < 2000) begin
            tick();
            k++;
        end
        chk("drain_timeout", 512'(tx_q.size() + cks_tx_q.size() + mdl_q.size()), 512'd0);
    endtask

    task automatic do_reset();
        tx_q.delete();
        cks_tx_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_q.delete();
        cks_mdl.delete();
        exp_first = 1;
        stall_prev = 0;
    endtask

    initial begin
        run(2);
        chk("rst_valid", 512'(M_AXIS_TVALID), 512'd0);
        chk("rst_data", M_AXIS_TDATA, 512'd0);
        chk("rst_keep", 512'(M_AXIS_TKEEP), 512'd0);
        chk("rst_last", 512'(M_AXIS_TLAST), 512'd0);
        chk("rst_err", 512'(err_oversize), 512'd0);
        chk("rst_s_ready", 512'({S_AXIS_TREADY, S_CKS_TREADY}), 512'd3);
        rst = 1'b0;

        // 2-beat zero packet, checksum arrives 3 cycles after TLAST
        push_pkt(2, 1, '1, 1);
        send_all();
        run(3);
        chk("hold_no_cks", 512'(M_AXIS_TVALID), 512'd0);
        cks_tx_q.push_back(16'hBEEF);
        drain();
        tmp = '0;
        tmp[295:288] = 8'hEF;
        tmp[303:296] = 8'hBE;
        chk("beef_beat0", first_out, tmp);

        // checksum before any data, 1-beat partial-keep packet
        cks_tx_q.push_back(16'h1234);
        run(3);
        push_pkt(1, 0, 64'h0000_003F_FFFF_FFFF, 1);
        drain();
        chk("cks_1234", 512'(first_out[303:288]), 512'h1234);

        // three 4-beat packets back to back, checksums preloaded
        for (int i = 1; i <= 3; i++) cks_tx_q.push_back(16'(i));
        run(4);
        out_cnt = 0;
        for (int i = 0; i < 3; i++) push_pkt(4, 0, '1, 1);
        drain();
        chk("b2b_count", 512'(out_cnt), 512'd12);
        chk("b2b_span", 512'(last_cyc - first_cyc + 1), 512'd12);

        // random backpressure and random ingress timing
        bp = 1;
        en_rand = 1;
        for (int i = 0; i < 8; i++) begin
            cks_tx_q.push_back(16'($urandom));
            push_pkt($urandom_range(1, 8), 0, 64'($urandom) | 64'(1), 1);
        end
        drain();
        bp = 0;
        en_rand = 0;
        chk("no_err_legal", 512'(err_oversize), 512'd0);

        // 32-beat packet with no checksum fills the buffer
        push_pkt(32, 0, '1, 1);
        send_all();
        run(2);
        chk("full_s_ready", 512'(S_AXIS_TREADY), 512'd0);
        chk("oversize_err", 512'(err_oversize), 512'd1);
        chk("full_no_out", 512'(M_AXIS_TVALID), 512'd0);
        do_reset();
        chk("post_rst_err", 512'(err_oversize), 512'd0);
        chk("post_rst_valid", 512'(M_AXIS_TVALID), 512'd0);
        chk("post_rst_s_ready", 512'(S_AXIS_TREADY), 512'd1);

        // reset mid-packet with its checksum already present
        hold_lo = 1;
        cks_tx_q.push_back(16'h7777);
        push_pkt(2, 0, '1, 0);
        send_all();
        run(3);
        do_reset();
        hold_lo = 0;
        chk("midpkt_rst_valid", 512'(M_AXIS_TVALID), 512'd0);
        cks_tx_q.push_back(16'hA5A5);
        push_pkt(2, 0, '1, 1);
        drain();
        chk("cks_a5a5", 512'(first_out[303:288]), 512'hA5A5);

        // checksum FIFO fills with no packets present
        for (int i = 0; i < 5; i++) cks_tx_q.push_back(16'(i + 16'h100));
        run(8);
        chk("cks_full_ready", 512'(S_CKS_TREADY), 512'd0);
        chk("cks_full_left", 512'(cks_tx_q.size()), 512'd1);
        chk("cks_only_no_out", 512'(M_AXIS_TVALID), 512'd0);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
